// File: rtl/raster_ram_shim.sv
// Scanner-to-RAM shim: takes committed ADC samples and writes them into a
// circular buffer in system RAM through a single-word Wishbone classic master.
module raster_ram_shim #(
  parameter int                  DATA_WID  = 24,
  parameter int                  BUS_WID   = 32,
  parameter int                  ADDR_WID  = 32,
  parameter logic [ADDR_WID-1:0] BASE_ADDR = '0,
  parameter int                  MAX_WORDS = 1024,
  parameter int                  PTR_WID   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WID-1:0]   data,
  input  logic                  mem_commit,
  output logic                  mem_finished,
  output logic                  bus_cyc,
  output logic                  bus_stb,
  output logic                  bus_we,
  output logic [ADDR_WID-1:0]   bus_adr,
  output logic [BUS_WID-1:0]    bus_dat_w,
  output logic [BUS_WID/8-1:0]  bus_sel,
  input  logic                  bus_ack,
  input  logic                  bus_err,
  input  logic [PTR_WID-1:0]    rd_ptr,
  input  logic                  clear,
  output logic [PTR_WID-1:0]    wr_ptr,
  output logic [PTR_WID-1:0]    words_avail,
  output logic                  full,
  output logic                  bus_error
);

  // state      | meaning
  // IDLE       | waiting for a scanner commit; clear is honoured here only
  // WAIT_SPACE | sample latched, waiting for room in the buffer
  // BUS_WRITE  | Wishbone write in flight, outputs held until ack/err
  // ACK        | mem_finished high until the scanner drops mem_commit
  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WAIT_SPACE = 2'd1;
  localparam logic [1:0] BUS_WRITE  = 2'd2;
  localparam logic [1:0] ACK        = 2'd3;

  localparam logic [PTR_WID:0]   MAX_W    = (PTR_WID+1)'(MAX_WORDS);
  localparam logic [PTR_WID-1:0] LAST_IDX = PTR_WID'(MAX_WORDS - 1);

  logic [1:0]          state;
  logic [BUS_WID-1:0]  sample;
  logic [PTR_WID:0]    diff;
  logic [PTR_WID:0]    avail_ext;
  logic [PTR_WID-1:0]  avail_next;
  logic [PTR_WID-1:0]  wr_ptr_inc;
  logic [ADDR_WID-1:0] adr_next;
  logic                space_ok;

  // An out-of-range rd_ptr is treated the same as a full buffer.
  always_comb begin
    diff       = {1'b0, wr_ptr} - {1'b0, rd_ptr};
    avail_ext  = diff[PTR_WID] ? (diff + MAX_W) : diff;
    avail_next = avail_ext[PTR_WID-1:0];
    wr_ptr_inc = (wr_ptr == LAST_IDX) ? '0 : (wr_ptr + PTR_WID'(1));
    adr_next   = BASE_ADDR + (ADDR_WID'(wr_ptr) << 2);
    space_ok   = !full && ({1'b0, rd_ptr} < MAX_W);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sample       <= '0;
      mem_finished <= 1'b0;
      bus_cyc      <= 1'b0;
      bus_stb      <= 1'b0;
      bus_we       <= 1'b0;
      bus_adr      <= '0;
      bus_dat_w    <= '0;
      bus_sel      <= '0;
      wr_ptr       <= '0;
      words_avail  <= '0;
      full         <= 1'b0;
      bus_error    <= 1'b0;
    end else begin
      words_avail <= avail_next;
      full        <= (avail_next == LAST_IDX);
      case (state)
        IDLE: begin
          if (clear) begin
            wr_ptr    <= '0;
            bus_error <= 1'b0;
          end else if (mem_commit) begin
            sample <= BUS_WID'($signed(data));
            state  <= WAIT_SPACE;
          end
        end
        WAIT_SPACE: begin
          if (space_ok) begin
            bus_adr   <= adr_next;
            bus_dat_w <= sample;
            bus_sel   <= '1;
            bus_cyc   <= 1'b1;
            bus_stb   <= 1'b1;
            bus_we    <= 1'b1;
            state     <= BUS_WRITE;
          end
        end
        BUS_WRITE: begin
          // An error still advances the pointer so the scanner never deadlocks.
          if (bus_ack || bus_err) begin
            bus_cyc      <= 1'b0;
            bus_stb      <= 1'b0;
            bus_we       <= 1'b0;
            bus_sel      <= '0;
            wr_ptr       <= wr_ptr_inc;
            mem_finished <= 1'b1;
            if (bus_err) bus_error <= 1'b1;
            state        <= ACK;
          end
        end
        ACK: begin
          if (!mem_commit) begin
            mem_finished <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
